// File: rtl/updown_pkg.sv
// Shared FSM encoding and default timing values for the up/down button conditioner.
package updown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd4;
  localparam int unsigned DEF_HOLD_CYCLES     = 32'd16;
  localparam int unsigned DEF_REPEAT_CYCLES   = 32'd8;
  localparam bit          DEF_REPEAT_EN       = 1'b1;

  localparam int unsigned DB_CNT_W  = 32'd8;
  localparam int unsigned TMR_CNT_W = 32'd16;

endpackage

// File: rtl/btn_debounce.sv
// One button lane: 2-flop synchronizer, debouncer and press/hold/repeat FSM.
// req_o is a registered one-cycle request; the top registers it once more.
module btn_debounce
  import updown_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic req_o
);

  localparam logic [DB_CNT_W-1:0]  DB_LAST   = DB_CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [TMR_CNT_W-1:0] HOLD_LAST = TMR_CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [TMR_CNT_W-1:0] RPT_LAST  = TMR_CNT_W'(REPEAT_CYCLES - 32'd1);

  logic [1:0]           sync_q;
  logic                 level_q, level_d;
  logic [DB_CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic                 rise_s, fall_s;
  btn_state_e           state_q;
  logic [TMR_CNT_W-1:0] tmr_q;
  logic                 req_q;

  // Debounce run counter; the level flips on the cycle the run reaches DEBOUNCE_CYCLES.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d  = sync_q[1];
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_CNT_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  assign rise_s = level_d & ~level_q;
  assign fall_s = ~level_d & level_q;

  // Synchronizer and debounced level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Press FSM reacts to the level edge as it is accepted, so req_q lines up with level_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tmr_q <= '0;
          if (rise_s) begin
            state_q <= ST_HOLD;
            req_q   <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (fall_s) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
          end else if (tmr_q == HOLD_LAST) begin
            if (REPEAT_EN) begin
              state_q <= ST_REPEAT;
              tmr_q   <= '0;
              req_q   <= 1'b1;
            end else begin
              tmr_q <= tmr_q;
            end
          end else begin
            tmr_q <= tmr_q + TMR_CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (fall_s) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
          end else if (tmr_q == RPT_LAST) begin
            tmr_q <= '0;
            req_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMR_CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tmr_q   <= '0;
        end
      endcase
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/updown_btn_conditioner.sv
// Conditions two raw buttons into one-cycle up/down counter pulses.
// Simultaneous requests are suppressed and reported on conflict.
module updown_btn_conditioner
  import updown_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down,
  output logic conflict
);

  logic up_req_s, down_req_s;
  logic up_d, down_d, conflict_d;
  logic up_q, down_q, conflict_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (REPEAT_EN)
  ) u_up (
    .clk  (clk),
    .rst_n(reset),
    .btn_i(btn_up),
    .req_o(up_req_s)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .REPEAT_EN      (REPEAT_EN)
  ) u_down (
    .clk  (clk),
    .rst_n(reset),
    .btn_i(btn_down),
    .req_o(down_req_s)
  );

  // Arbitration: a same-cycle pair is dropped and flagged instead of counted.
  always_comb begin
    up_d       = 1'b0;
    down_d     = 1'b0;
    conflict_d = 1'b0;
    if (up_req_s && down_req_s) begin
      conflict_d = 1'b1;
    end else begin
      up_d   = up_req_s;
      down_d = down_req_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      up_q       <= up_d;
      down_q     <= down_d;
      conflict_q <= conflict_d;
    end
  end

  assign up       = up_q;
  assign down     = down_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_updown_btn_conditioner.sv
// Bench: default-parameter and REPEAT_EN=0 instances share the buttons; a press
// model predicts every pulse into a scoreboard checked edge by edge.
module tb_updown_btn_conditioner;

  localparam int D = 4;
  localparam int H = 16;
  localparam int R = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic up0, down0, conflict0;
  logic up1, down1, conflict1;

  always #5 clk = ~clk;

  updown_btn_conditioner dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .up(up0), .down(down0), .conflict(conflict0)
  );

  updown_btn_conditioner #(.REPEAT_EN(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .up(up1), .down(down1), .conflict(conflict1)
  );

  // kind: 1 = up, 2 = down, 3 = conflict
  typedef struct { int edge_no; int dut; int kind; } ev_t;
  typedef struct {
    int us; int ul; int ds; int dl; logic [7:0] dmask; int ncyc;
    int exp_up0; int exp_dn0; int exp_cf0; int exp_tot1;
  } vec_t;

  ev_t  sb_q[$];
  vec_t vecs[12];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   base = 0;
  int   seen[2][4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc - base);
    end
  endtask

  // A clean press stable on edges s..s+l-1 pulses at s+D+2, then at +H and every R.
  function automatic bit pulse_at(input int s, input int l, input int p, input bit ren);
    int first;
    first = s + D + 2;
    if (l < D || p < first || p > s + l + D + 1) return 1'b0;
    if (p == first) return 1'b1;
    if (!ren || p < first + H) return 1'b0;
    return ((p - first - H) % R) == 0;
  endfunction

  task automatic push_pair(input int p, input int d, input bit u, input bit dn);
    if (u && dn) sb_q.push_back('{p + base, d, 3});
    else if (u) sb_q.push_back('{p + base, d, 1});
    else if (dn) sb_q.push_back('{p + base, d, 2});
  endtask

  task automatic observe(input int d, input logic u, input logic dn, input logic cf);
    int   kind;
    int   n;
    ev_t  ev;
    n = int'(u) + int'(dn) + int'(cf);
    kind = cf ? 3 : (dn ? 2 : (u ? 1 : 0));
    if (n > 1) check($sformatf("dut%0d_exclusive", d), n, 1);
    if (kind != 0) begin
      seen[d][kind]++;
      if (sb_q.size() == 0) begin
        check($sformatf("dut%0d_unexpected_pulse", d), kind, 0);
      end else begin
        ev = sb_q.pop_front();
        check($sformatf("dut%0d_pulse_edge", d), cyc, ev.edge_no);
        check($sformatf("dut%0d_pulse_dut", d), d, ev.dut);
        check($sformatf("dut%0d_pulse_kind", d), kind, ev.kind);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    observe(0, up0, down0, conflict0);
    observe(1, up1, down1, conflict1);
  endtask

  task automatic clear_seen();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) seen[d][k] = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int e;
    base = cyc;
    clear_seen();
    for (int p = 1; p <= v.ncyc; p++)
      for (int d = 0; d < 2; d++)
        push_pair(p, d, pulse_at(v.us, v.ul, p, d == 0), pulse_at(v.ds, v.dl, p, d == 0));
    for (int rel = 0; rel < v.ncyc; rel++) begin
      e = rel + 1;
      btn_up   = (e >= v.us && e < v.us + v.ul);
      btn_down = (e >= v.ds && e < v.ds + v.dl) || (e <= 8 && v.dmask[e - 1]);
      step();
    end
    check($sformatf("vec%0d_missing_pulses", idx), sb_q.size(), 0);
    sb_q.delete();
    check($sformatf("vec%0d_up_count", idx), seen[0][1], v.exp_up0);
    check($sformatf("vec%0d_down_count", idx), seen[0][2], v.exp_dn0);
    check($sformatf("vec%0d_conflict_count", idx), seen[0][3], v.exp_cf0);
    check($sformatf("vec%0d_norepeat_count", idx), seen[1][1] + seen[1][2] + seen[1][3], v.exp_tot1);
  endtask

  initial begin
    //          us  ul  ds  dl  dmask  ncyc up0 dn0 cf0 tot1
    vecs[0]  = '{1, 200, 0,  0, 8'h00, 220, 24, 0,  0,  1};  // long up press, repeats
    vecs[1]  = '{0,   0, 1, 10, 8'h00,  30,  0, 1,  0,  1};  // short down press
    vecs[2]  = '{1,  10, 1, 10, 8'h00,  30,  0, 0,  1,  1};  // same-edge conflict
    vecs[3]  = '{1,  30, 5, 30, 8'h00,  50,  3, 3,  0,  2};  // overlapping, offset presses
    vecs[4]  = '{1,   3, 0,  0, 8'h00,  20,  0, 0,  0,  0};  // glitch below debounce
    vecs[5]  = '{1,   4, 0,  0, 8'h00,  20,  1, 0,  0,  1};  // exactly debounce length
    vecs[6]  = '{1,  16, 0,  0, 8'h00,  35,  1, 0,  0,  1};  // released just before repeat
    vecs[7]  = '{1,  17, 0,  0, 8'h00,  35,  2, 0,  0,  1};  // released just after repeat
    vecs[8]  = '{0,   0, 5, 12, 8'h05,  35,  0, 1,  0,  1};  // bounce 1,0,1,0 then hold
    vecs[9]  = '{1, 100, 0,  0, 8'h00, 120, 12, 0,  0,  1};  // 100-cycle hold, first
    vecs[10] = '{1, 100, 0,  0, 8'h00, 120, 12, 0,  0,  1};  // 100-cycle hold, second
    vecs[11] = '{1,  10, 1, 30, 8'h00,  50,  0, 2,  1,  1};  // conflict, down keeps repeating

    reset = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_up0", up0, 0);
    check("reset_down0", down0, 0);
    check("reset_conflict0", conflict0, 0);
    check("reset_outputs_nr", {up1, down1, conflict1}, 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Held press, reset mid-repeat for edges 30..32, press resumes from edge 33.
    base = cyc;
    clear_seen();
    for (int p = 1; p <= 80; p++)
      for (int d = 0; d < 2; d++)
        push_pair(p, d, (p <= 29 && pulse_at(1, 1000, p, d == 0)) ||
                        (p >= 33 && pulse_at(33, 31, p, d == 0)), 1'b0);
    for (int rel = 0; rel < 80; rel++) begin
      int e;
      e = rel + 1;
      btn_up = (e < 64);
      btn_down = 1'b0;
      if (e == 30) begin
        reset = 1'b0;
        #1;
        check("reset_async_clear", {up0, down0, conflict0, up1, down1, conflict1}, 0);
      end
      if (e == 33) reset = 1'b1;
      step();
      if (e >= 30 && e <= 32) check("in_reset_outputs", {up0, down0, conflict0}, 0);
    end
    check("rst_seq_missing_pulses", sb_q.size(), 0);
    sb_q.delete();
    check("rst_seq_up_count", seen[0][1], 5);
    check("rst_seq_norepeat_count", seen[1][1], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_btn_conditioner.md
UPDOWN_BTN_CONDITIONER -- requirements
Module: updown_btn_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a level change (legal range 1..255).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16: cycles from the first pulse of a press to the first auto-repeat pulse (legal range 2..65535).
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 8: cycles between subsequent auto-repeat pulses (legal range 2..65535).
REQ-004 The block SHALL have parameter REPEAT_EN, default 1: 1 enables auto-repeat, 0 gives one pulse per press.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 btn_up  input  1  raw, asynchronous, bouncing "count up" button, active-high.
REQ-008 btn_down  input  1  raw, asynchronous, bouncing "count down" button, active-high.
REQ-009 up  output  1  one-cycle registered pulse that drives the downstream up/down counter's up input.
REQ-010 down  output  1  one-cycle registered pulse that drives the downstream up/down counter's down input.
REQ-011 conflict  output  1  one-cycle registered pulse that flags a suppressed simultaneous up/down request.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 The debounced level SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the run count to 0.
REQ-014 Each button SHALL have its own FSM: IDLE -> HOLD on debounced rise (issue request); HOLD -> REPEAT after HOLD_CYCLES (issue request); REPEAT issues a request every REPEAT_CYCLES; any state -> IDLE on debounced fall, with no request on that cycle.
REQ-015 When REPEAT_EN=0, HOLD SHALL never leave except on debounced fall.
REQ-016 Latency: with a clean press stable from clock edge 1, up (or down) SHALL be high for exactly the cycle after edge DEBOUNCE_CYCLES+3.
REQ-017 If the up and down requests occur in the same cycle, up and down SHALL both stay 0 and conflict SHALL pulse for 1 cycle; both FSMs still advance normally.
REQ-018 up and down SHALL never be high in the same cycle, and no output pulse SHALL be wider than 1 cycle.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no state change.
REQ-020 The hold and repeat counters SHALL saturate or reload only; they SHALL never wrap into a spurious pulse.

Reset
REQ-021 Asserting reset (low) SHALL immediately clear the synchronizers, debounced levels, counters and outputs to 0, and return both FSMs to IDLE.
REQ-022 A button already held at reset release SHALL be treated as a new press: one pulse at the REQ-016 latency, measured from the first edge after release.
REQ-023 Reset asserted mid-repeat SHALL abort the repeat with no further pulse until a new debounced press.

Structure
REQ-024 FSM state encoding (IDLE/HOLD/REPEAT) and the default parameter values SHALL live in shared package updown_pkg.
REQ-025 One sub-module, btn_debounce (synchronizer, debounce and per-button FSM, emitting a request pulse), SHALL be instantiated twice; the top level SHALL hold only the conflict arbitration and the output registers.

Verification
REQ-026 Clean 200-cycle press on btn_up with defaults -> up pulses at edge 7, then every 8 cycles starting at edge 23; down=0 and conflict=0 throughout.
REQ-027 btn_down bounces 1,0,1,0 on alternate cycles, then holds high -> exactly one down pulse, 7 edges after the final rise.
REQ-028 Both buttons rise on the same edge and are held 10 cycles -> conflict=1 for one cycle at edge 7, up=down=0 throughout.
REQ-029 btn_up held, reset low for 3 cycles at edge 30, then released -> outputs 0 during reset, a new up pulse 7 edges after release, repeats follow.
REQ-030 REPEAT_EN=0, btn_up held 100 cycles and pressed twice -> exactly 2 up pulses; a 3-cycle glitch -> 0 pulses.
